// File: rtl/sha256_msg_sched_if.sv
// SHA-256 message-schedule stream interface.
// Groups the message-word input stream and the schedule-word output stream.
// The slave modport is the schedule generator's view. The master modport is
// the view of the environment that feeds message words and consumes W words.
interface sha256_msg_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_idx;
  logic        w_last;

  modport slave (
    input  in_valid, in_word, w_ready,
    output in_ready, w_valid, w_word, w_idx, w_last
  );

  modport master (
    output in_valid, in_word, w_ready,
    input  in_ready, w_valid, w_word, w_idx, w_last
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule generator.
// The block loads 16 message words into a 16-word sliding window. It then
// streams W[0..NUM_WORDS-1], one word per accepted handshake. Each handshake
// shifts the window and appends W[t+16], which is computed from the window
// in a single combinational stage.
// Optional feature: define SHA256_SCHED_ABORT_EN to add the synchronous
// 'abort' flush input.
module sha256_msg_sched #(
  parameter int NUM_WORDS = 64
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SHA256_SCHED_ABORT_EN
  input  logic abort,
`endif
  sha256_msg_sched_if.slave bus
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  typedef enum logic {S_LOAD = 1'b0, S_EMIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic [31:0] r_win [16];
  logic        w_shift;
  logic [31:0] w_shift_in;
  logic [31:0] w_nxt;
  logic        w_abort;
  logic        w_last;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef SHA256_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // W[t+16] from the current window. Carries past bit 31 are dropped.
  assign w_nxt = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];

  assign w_last       = (r_state == S_EMIT) && (r_cnt == LAST_IDX);
  assign bus.in_ready = (r_state == S_LOAD);
  assign bus.w_valid  = (r_state == S_EMIT);
  assign bus.w_word   = r_win[0];
  assign bus.w_idx    = r_cnt;
  assign bus.w_last   = w_last;

  // Next state, next count, and window shift control. Abort overrides any handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_shift_in  = bus.in_word;
    if (w_abort) begin
      w_state_nxt = S_LOAD;
      w_cnt_nxt   = 6'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.in_valid) begin
            w_shift = 1'b1;
            if (r_cnt == 6'd15) begin
              w_cnt_nxt   = 6'd0;
              w_state_nxt = S_EMIT;
            end else begin
              w_cnt_nxt = r_cnt + 6'd1;
            end
          end
        end
        S_EMIT: begin
          if (bus.w_ready) begin
            w_shift    = 1'b1;
            w_shift_in = w_nxt;
            if (w_last) begin
              w_cnt_nxt   = 6'd0;
              w_state_nxt = S_LOAD;
            end else begin
              w_cnt_nxt = r_cnt + 6'd1;
            end
          end
        end
      endcase
    end
  end

  // State and word-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sliding window. win[0] is the oldest word and is presented as w_word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
    end else if (w_shift) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_shift_in;
    end
  end

endmodule
